rr_arbiter_four: RTL and testbench
==================================

# rr_arbiter_four

Round-robin arbiter sharing one resource among four requesters. Winner held as 2-bit index, expanded through the team's 2-to-4 decode into a one-hot grant vector. Sits in front of any single-port resource the decoder fans out to: decoder selects which consumer is enabled, this block decides which consumer and for how long. Registered outputs, one-cycle arbitration, fair rotation, optional hold-limit timeout.

## Interface

Parameters:
- HOLD_MAX, 8: maximum consecutive grant cycles per winner; used only when RR_HOLD_LIMIT_EN is defined; legal range 2..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- req  input  4  request lines; req[i] high = requester i wants the resource.
- gnt  output  4  one-hot grant; gnt[i] = gnt_valid & (gnt_idx == i); bit order matches decoder outputs p,q,r,s for index 00,01,10,11.
- gnt_idx  output  2  index of current winner.
- gnt_valid  output  1  high while a grant is active.
- timeout  output  1  one-cycle pulse on a forced release; tied 0 when RR_HOLD_LIMIT_EN is undefined.

## Operation

- State: 2-state FSM IDLE/GRANT; 2-bit rotation pointer ptr; 8-bit hold counter cnt (macro builds only).
- Reset values: state=IDLE, ptr=0, gnt_idx=0, gnt_valid=0, gnt=0000, timeout=0, cnt=0.
- IDLE: if req==0, stay. Otherwise pick first i in order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with req[i]=1. Load gnt_idx=i, gnt_valid=1, cnt=0, go GRANT.
- GRANT, normal release: req[gnt_idx]=0 at an edge clears gnt_valid, sets ptr=gnt_idx+1 (2-bit wrap, 3->0), goes IDLE.
- GRANT, hold: req[gnt_idx]=1 keeps grant; cnt increments, saturating at 255.
- Requests from non-winners never preempt a grant. They are not latched; a requester must hold req high until granted.
- Pointer rule: last winner becomes lowest priority. With all four requesting continuously, grant sequence is 0,1,2,3,0,...
- gnt always decoded from registered gnt_idx/gnt_valid. Never more than one bit high. gnt=0000 whenever gnt_valid=0.

## Timing

- Arbitration latency: req rises before edge N in IDLE -> gnt_valid=1 after edge N (1 cycle).
- Release latency: req[gnt_idx] falls before edge M -> gnt_valid=0 after edge M.
- Mandatory one IDLE cycle between consecutive grants. Back-to-back grants are spaced by at least one gnt_valid=0 cycle.
- Simultaneous release by winner and new requests at the same edge: release wins. Arbitration happens at the following edge using the updated ptr.
- rst high at any edge, including mid-grant: all state returns to reset values after that edge. rst overrides release and timeout.
- req changes between edges have no effect. Only edge-sampled values matter.

## Configuration

- RR_HOLD_LIMIT_EN defined: in GRANT, when cnt==HOLD_MAX-1 and req[gnt_idx] still 1 at an edge, forced release occurs. gnt_valid goes to 0, ptr=gnt_idx+1, state goes IDLE, timeout=1 for exactly that following cycle. Winner may be regranted later only by normal rotation. A grant therefore lasts at most HOLD_MAX cycles.
- RR_HOLD_LIMIT_EN undefined: no counter logic, timeout tied 0, grant held indefinitely while req[gnt_idx]=1.

## Test plan

- Reset: hold rst=1 for 2 edges with req=1111 -> gnt=0000, gnt_idx=00, gnt_valid=0, timeout=0.
- Single requester: req=0100 one cycle after reset, held 3 edges, then dropped -> gnt=0100 for 3 cycles, then 0000; next req=0100 is granted again; ptr=3.
- Full rotation: req=1111 held, each winner drops its req 2 cycles after grant and reasserts after release -> grant order 0,1,2,3,0, with one idle cycle between each.
- Priority after wrap: winner 3 releases while req=1001 -> next grant is index 0 (gnt=0001), not 3.
- Mid-grant reset: gnt=0010 active, rst=1 at one edge -> gnt=0000, ptr=0 afterwards; req=1111 then grants index 0.
- Hold limit (RR_HOLD_LIMIT_EN, HOLD_MAX=4): req=0001 held constantly -> gnt_valid high exactly 4 cycles, timeout pulses 1 cycle, idle 1 cycle, regrant index 0. Same stimulus without macro -> gnt=0001 held for the full 20-cycle run, timeout=0.

Source files
------------

// File: rtl/rr_arbiter_four.sv
// Four-way round-robin arbiter with registered grant index and one-hot decoded grant.
// Optional hold-limit timeout is enabled by defining RR_HOLD_LIMIT_EN.
module rr_arbiter_four #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_reg;
    logic [1:0] ptr_reg;
    logic [1:0] idx_reg;
    logic       valid_reg;
    logic [1:0] pick_idx;
    logic       pick_found;
    logic       hold_expired;

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("rr_arbiter_four: HOLD_MAX must lie in 2..255");
    end

    // Scan from the highest offset down so the candidate nearest ptr wins.
    always_comb begin
        pick_idx   = ptr_reg;
        pick_found = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr_reg + 2'(k)]) begin
                pick_idx   = ptr_reg + 2'(k);
                pick_found = 1'b1;
            end
        end
    end

`ifdef RR_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] cnt_reg;
    logic       timeout_reg;

    assign hold_expired = (cnt_reg == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg     <= 8'd0;
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= (state_reg == GRANT) && req[idx_reg] && hold_expired;
            if (state_reg == IDLE)
                cnt_reg <= 8'd0;
            else if (cnt_reg != 8'hFF)
                cnt_reg <= cnt_reg + 8'd1;
        end
    end

    assign timeout = timeout_reg;
`else
    assign hold_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= 2'd0;
            idx_reg   <= 2'd0;
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        idx_reg   <= pick_idx;
                        valid_reg <= 1'b1;
                        state_reg <= GRANT;
                    end
                end
                GRANT: begin
                    // Voluntary release and forced release both demote the winner.
                    if (!req[idx_reg] || hold_expired) begin
                        valid_reg <= 1'b0;
                        ptr_reg   <= idx_reg + 2'd1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign gnt_idx   = idx_reg;
    assign gnt_valid = valid_reg;

    for (genvar gi = 0; gi < 4; gi++) begin : g_decode
        assign gnt[gi] = valid_reg & (idx_reg == 2'(gi));
    end

endmodule

// File: tb/tb_rr_arbiter_four.sv
// Directed scoreboard bench for rr_arbiter_four: expectations queued at drive time,
// popped and checked one clock later with immediate assertions.
module tb_rr_arbiter_four;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    typedef struct {
        string      tag;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       idx_care;
        logic       valid;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    rr_arbiter_four #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Drive one edge worth of inputs, queue the expectation, check after the edge.
    task automatic step(input string tag, input logic r, input logic [3:0] rq,
                        input logic v, input logic [1:0] idx, input logic idx_care,
                        input logic to);
        exp_t e;
        exp_t got;
        logic [8:0] obs_vec;
        logic [8:0] exp_vec;
        e.tag      = tag;
        e.valid    = v;
        e.idx      = idx;
        e.idx_care = idx_care;
        e.gnt      = v ? (4'b0001 << idx) : 4'b0000;
        e.to       = to;
        rst = r;
        req = rq;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got     = exp_q.pop_front();
        obs_vec = {gnt, (got.idx_care ? gnt_idx : 2'b00), gnt_valid, timeout};
        exp_vec = {got.gnt, (got.idx_care ? got.idx : 2'b00), got.valid, got.to};
        vectors++;
        assert (obs_vec === exp_vec)
        else begin
            miscompares++;
            $error("FAIL %s: got gnt=%b idx=%0d valid=%b to=%b, want gnt=%b idx=%0d valid=%b to=%b",
                   got.tag, gnt, gnt_idx, gnt_valid, timeout,
                   got.gnt, got.idx, got.valid, got.to);
        end
        $display("vec %0d %s req=%b -> gnt=%b idx=%0d valid=%b to=%b",
                 vectors, got.tag, rq, gnt, gnt_idx, gnt_valid, timeout);
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        @(posedge clk);
        #1;

        // Reset with all requesting: nothing granted.
        step("reset0", 1'b1, 4'b1111, 1'b0, 2'd0, 1'b1, 1'b0);
        step("reset1", 1'b1, 4'b1111, 1'b0, 2'd0, 1'b1, 1'b0);
        step("idle",   1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0);

        // Single requester 2: held three cycles, released, regranted.
        step("single_g1", 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0);
        step("single_g2", 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0);
        step("single_g3", 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0);
        step("single_rel", 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        step("single_regrant", 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0);
        step("single_rel2", 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

        // Pointer now 3: all requesting picks 3; its release wraps priority to 0.
        step("ptr3_pick", 1'b0, 4'b1111, 1'b1, 2'd3, 1'b1, 1'b0);
        step("wrap_rel",  1'b0, 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0);
        step("wrap_pick0", 1'b0, 4'b1001, 1'b1, 2'd0, 1'b1, 1'b0);
        step("wrap_rel0", 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

        // Mid-grant reset restores pointer 0.
        step("mid_g1",  1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0);
        step("mid_rst", 1'b1, 4'b0010, 1'b0, 2'd0, 1'b1, 1'b0);

        // Full rotation with non-winners requesting throughout (no preemption).
        for (int w = 0; w < 4; w++) begin
            step($sformatf("rot%0d_g1", w), 1'b0, 4'b1111, 1'b1, 2'(w), 1'b1, 1'b0);
            step($sformatf("rot%0d_g2", w), 1'b0, 4'b1111, 1'b1, 2'(w), 1'b1, 1'b0);
            step($sformatf("rot%0d_rel", w), 1'b0, 4'b1111 & ~(4'b0001 << w),
                 1'b0, 2'd0, 1'b0, 1'b0);
        end
        step("rot_wrap0", 1'b0, 4'b1111, 1'b1, 2'd0, 1'b1, 1'b0);
        step("rot_done",  1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

        // Requester 0 held constantly for 20 cycles.
        for (int k = 0; k < 20; k++) begin
`ifdef RR_HOLD_LIMIT_EN
            if (k % 5 == 4)
                step($sformatf("hold%0d", k), 1'b0, 4'b0001, 1'b0, 2'd0, 1'b0, 1'b1);
            else
                step($sformatf("hold%0d", k), 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0);
`else
            step($sformatf("hold%0d", k), 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
